// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master BRAM arbiter: FSM states, request kind
// encoding and the grant-selection helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbRdIssue = 2'd1,
    ArbRdData  = 2'd2,
    ArbWrite   = 2'd3
  } ArbState;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Returns the master index to serve; the caller guarantees at least one pending.
  function automatic logic pick_winner(input logic p0, input logic p1,
                                       input logic last_grant, input logic fixed_prio);
    if (p0 && p1) return fixed_prio ? 1'b0 : ~last_grant;
    return p1 && !p0;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Per-master request capture: latches one strobe, holds it pending until the
// arbiter retires it, flags overruns and keeps the last read result.
module arb_req_latch
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int RAM_AW     = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  input  logic                  rstrb,
  input  logic                  clear,
  input  logic                  load_rdata,
  input  logic [31:0]           ram_rdata,
  output logic                  pending,
  output logic                  is_write,
  output logic [RAM_AW-1:0]     word_addr,
  output logic [31:0]           wdata_q,
  output logic [3:0]            wmask_q,
  output logic [31:0]           rdata,
  output logic                  rbusy,
  output logic                  wbusy,
  output logic                  err_overrun
);

  logic kind;
  logic req;
  logic unused_addr;

  assign req         = rstrb | (|wmask);
  assign unused_addr = ^{addr[ADDR_WIDTH-1:RAM_AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      kind        <= REQ_READ;
      word_addr   <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata       <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (clear) pending <= 1'b0;
      if (req) begin
        if (pending) begin
          err_overrun <= 1'b1;
        end else begin
          pending   <= 1'b1;
          kind      <= (|wmask) ? REQ_WRITE : REQ_READ;
          word_addr <= addr[RAM_AW+1:2];
          wdata_q   <= wdata;
          wmask_q   <= wmask;
        end
        // A write strobe that also carries rstrb wins, but the read is lost.
        if (rstrb && (|wmask)) err_overrun <= 1'b1;
      end
      if (load_rdata) rdata <= ram_rdata;
    end
  end

  assign is_write = (kind == REQ_WRITE);
  assign rbusy    = pending & ~is_write;
  assign wbusy    = pending & is_write;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port BRAM with 1-cycle registered
// read; round-robin or fixed priority between CPU (m0) and loader (m1).
//
// state      | meaning
// ArbIdle    | no access in flight; grant a pending master, writes issue here
// ArbRdIssue | read address held while the RAM samples it
// ArbRdData  | RAM data captured into the granted master's rdata
// ArbWrite   | dead cycle after a write, RAM write enables low
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int RAM_AW     = 14,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_rstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rbusy,
  output logic                  m0_wbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_rstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rbusy,
  output logic                  m1_wbusy,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wmask,
  input  logic [31:0]           ram_rdata,
  output logic [1:0]            err_overrun
);

  logic [1:0]        pending, is_write, clear, load_rdata;
  logic [RAM_AW-1:0] word_addr [2];
  logic [31:0]       wdata_q   [2];
  logic [3:0]        wmask_q   [2];

  ArbState           state, state_nxt;
  logic              last_grant, gnt_q, sel, grant;
  logic [RAM_AW-1:0] addr_q;

  arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_AW(RAM_AW)) u_req0 (
    .clk(clk), .reset(reset),
    .addr(m0_addr), .wdata(m0_wdata), .wmask(m0_wmask), .rstrb(m0_rstrb),
    .clear(clear[0]), .load_rdata(load_rdata[0]), .ram_rdata(ram_rdata),
    .pending(pending[0]), .is_write(is_write[0]), .word_addr(word_addr[0]),
    .wdata_q(wdata_q[0]), .wmask_q(wmask_q[0]), .rdata(m0_rdata),
    .rbusy(m0_rbusy), .wbusy(m0_wbusy), .err_overrun(err_overrun[0])
  );

  arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_AW(RAM_AW)) u_req1 (
    .clk(clk), .reset(reset),
    .addr(m1_addr), .wdata(m1_wdata), .wmask(m1_wmask), .rstrb(m1_rstrb),
    .clear(clear[1]), .load_rdata(load_rdata[1]), .ram_rdata(ram_rdata),
    .pending(pending[1]), .is_write(is_write[1]), .word_addr(word_addr[1]),
    .wdata_q(wdata_q[1]), .wmask_q(wmask_q[1]), .rdata(m1_rdata),
    .rbusy(m1_rbusy), .wbusy(m1_wbusy), .err_overrun(err_overrun[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ArbIdle;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= sel;
        gnt_q      <= sel;
        addr_q     <= ram_addr;
      end
    end
  end

  // Reset gates the grant so a latched write can never reach the RAM in the reset cycle.
  always_comb begin
    state_nxt  = state;
    clear      = '0;
    load_rdata = '0;
    ram_wmask  = '0;
    grant      = 1'b0;
    sel        = gnt_q;
    ram_addr   = addr_q;
    case (state)
      ArbIdle: begin
        if (!reset && (|pending)) begin
          grant    = 1'b1;
          sel      = pick_winner(pending[0], pending[1], last_grant, FIXED_PRIO != 0);
          ram_addr = word_addr[sel];
          if (is_write[sel]) begin
            ram_wmask  = wmask_q[sel];
            clear[sel] = 1'b1;
            state_nxt  = ArbWrite;
          end else begin
            state_nxt = ArbRdIssue;
          end
        end
      end
      ArbRdIssue: state_nxt = ArbRdData;
      ArbRdData: begin
        load_rdata[gnt_q] = 1'b1;
        clear[gnt_q]      = 1'b1;
        state_nxt         = ArbIdle;
      end
      ArbWrite: state_nxt = ArbIdle;
      default:  state_nxt = ArbIdle;
    endcase
  end

  assign ram_wdata = wdata_q[sel];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share master stimulus, each with its own behavioural BRAM.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;

  logic [31:0] m0_rdata, m1_rdata, fp_m0_rdata, fp_m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic        fp_m0_rbusy, fp_m0_wbusy, fp_m1_rbusy, fp_m1_wbusy;
  logic [13:0] ram_addr, fp_ram_addr;
  logic [31:0] ram_wdata, fp_ram_wdata, ram_rdata, fp_ram_rdata;
  logic [3:0]  ram_wmask, fp_ram_wmask;
  logic [1:0]  err_overrun, fp_err_overrun;

  logic [31:0] mem    [16384];
  logic [31:0] mem_fp [16384];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(24), .RAM_AW(14), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_rdata(ram_rdata), .err_overrun(err_overrun)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(24), .RAM_AW(14), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(fp_m0_rdata), .m0_rbusy(fp_m0_rbusy), .m0_wbusy(fp_m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(fp_m1_rdata), .m1_rbusy(fp_m1_rbusy), .m1_wbusy(fp_m1_wbusy),
    .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_wmask(fp_ram_wmask),
    .ram_rdata(fp_ram_rdata), .err_overrun(fp_err_overrun)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wmask[b])    mem[ram_addr][8*b +: 8]       <= ram_wdata[8*b +: 8];
      if (fp_ram_wmask[b]) mem_fp[fp_ram_addr][8*b +: 8] <= fp_ram_wdata[8*b +: 8];
    end
    ram_rdata    <= mem[ram_addr];
    fp_ram_rdata <= mem_fp[fp_ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = 32'h0;
      mem_fp[i] = 32'h0;
    end
    mem[0] = 32'h1;  mem_fp[0] = 32'h1;
    mem[1] = 32'h2;  mem_fp[1] = 32'h2;
    mem[4] = 32'h1234_5678; mem_fp[4] = 32'h1234_5678;

    // 1: reset held 3 cycles with a read strobe active
    idle_inputs();
    reset = 1'b1;
    m0_rstrb = 1'b1;
    tick();
    tick();
    chk("t1_wmask_in_reset", ram_wmask, 4'h0);
    tick();
    reset = 1'b0;
    m0_rstrb = 1'b0;
    tick();
    chk("t1_m0_rbusy", m0_rbusy, 1'b0);
    chk("t1_m0_wbusy", m0_wbusy, 1'b0);
    chk("t1_m1_busy", {m1_rbusy, m1_wbusy}, 2'b00);
    chk("t1_err", err_overrun, 2'b00);
    chk("t1_ram_wmask", ram_wmask, 4'h0);
    chk("t1_m0_rdata", m0_rdata, 32'h0);

    // 2: m0 half-word write
    m0_addr = 24'h10; m0_wdata = 32'hA5A5_A5A5; m0_wmask = 4'b0011;
    tick();
    m0_wmask = 4'h0;
    chk("t2_wbusy_t1", m0_wbusy, 1'b1);
    chk("t2_ram_wmask", ram_wmask, 4'b0011);
    chk("t2_ram_addr", ram_addr, 14'd4);
    tick();
    chk("t2_wbusy_t2", m0_wbusy, 1'b0);
    chk("t2_ram_word", mem[4], 32'h1234_A5A5);

    // 3: m0 reads it back
    m0_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0;
    chk("t3_rbusy_t1", m0_rbusy, 1'b1);
    tick();
    chk("t3_rbusy_t2", m0_rbusy, 1'b1);
    tick();
    chk("t3_rbusy_t3", m0_rbusy, 1'b1);
    tick();
    chk("t3_rbusy_t4", m0_rbusy, 1'b0);
    chk("t3_rdata", m0_rdata, 32'h1234_A5A5);

    // 4: simultaneous reads from a fresh reset, m0 wins the first tie
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_addr = 24'h0; m1_addr = 24'h4;
    m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    tick();
    tick();
    tick();
    chk("t4a_m0_rbusy", m0_rbusy, 1'b0);
    chk("t4a_m0_rdata", m0_rdata, 32'h1);
    chk("t4a_m1_rbusy", m1_rbusy, 1'b1);
    chk("t4a_m1_rdata_untouched", m1_rdata, 32'h0);
    chk("t4a_fp_m0_rdata", fp_m0_rdata, 32'h1);
    tick();
    tick();
    tick();
    chk("t4a_m1_rbusy_done", m1_rbusy, 1'b0);
    chk("t4a_m1_rdata", m1_rdata, 32'h2);

    // single m0 read so m0 holds last_grant, then a tie must go to m1 under RR
    m0_addr = 24'h0; m0_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0;
    tick();
    tick();
    tick();
    chk("t4s_m0_rdata", m0_rdata, 32'h1);

    m0_addr = 24'h4; m1_addr = 24'h0;
    m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    tick();
    tick();
    tick();
    chk("t4b_m1_rbusy", m1_rbusy, 1'b0);
    chk("t4b_m1_rdata", m1_rdata, 32'h1);
    chk("t4b_m0_rbusy", m0_rbusy, 1'b1);
    chk("t4b_m0_rdata_untouched", m0_rdata, 32'h1);
    chk("t4b_fp_m0_rbusy", fp_m0_rbusy, 1'b0);
    chk("t4b_fp_m0_rdata", fp_m0_rdata, 32'h2);
    chk("t4b_fp_m1_rbusy", fp_m1_rbusy, 1'b1);
    tick();
    tick();
    tick();
    chk("t4b_m0_rdata", m0_rdata, 32'h2);
    chk("t4b_fp_m1_rdata", fp_m1_rdata, 32'h1);

    // 5: m1 strobes again while its read is outstanding
    m1_addr = 24'h4; m1_rstrb = 1'b1;
    tick();
    m1_addr = 24'h0;
    chk("t5_m1_rbusy", m1_rbusy, 1'b1);
    tick();
    m1_rstrb = 1'b0;
    chk("t5_err", err_overrun, 2'b10);
    tick();
    tick();
    chk("t5_m1_rbusy_done", m1_rbusy, 1'b0);
    chk("t5_m1_rdata", m1_rdata, 32'h2);
    tick();
    chk("t5_dropped", m1_rbusy, 1'b0);

    // 6: reset while the read address is being issued
    m0_addr = 24'h4; m0_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0;
    tick();
    chk("t6_in_issue", dut.state, ArbRdIssue);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rbusy", m0_rbusy, 1'b0);
    chk("t6_state", dut.state, ArbIdle);
    chk("t6_err", err_overrun, 2'b00);
    chk("t6_rdata_cleared", m0_rdata, 32'h0);
    m0_rstrb = 1'b1;
    tick();
    m0_rstrb = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_after_rbusy", m0_rbusy, 1'b0);
    chk("t6_after_rdata", m0_rdata, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
